// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants, sequencer state type and chunk builders for the
// SHA-256d header sequencer.
package sha256_pkg;

    // SHA-256 initial hash value H0..H7, word 0 in the top bits.
    localparam logic [255:0] Sha256Iv = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    // First padding word: a single 1 bit right after the message.
    localparam logic [31:0] PadWord = 32'h8000_0000;

    // Message lengths in bits: the 80-byte header and the 32-byte first digest.
    localparam logic [63:0] HeaderLenBits = 64'd640;
    localparam logic [63:0] DigestLenBits = 64'd256;

    typedef enum logic [2:0] {
        StIdle,
        StC1,
        StW1,
        StC2,
        StW2,
        StC3,
        StW3,
        StOut
    } seq_state_e;

    // Second block of the first hash: last 16 header bytes plus padding and length.
    function automatic logic [511:0] build_chunk2(input logic [127:0] header_tail);
        return {header_tail, PadWord, 288'b0, HeaderLenBits};
    endfunction

    // Single block of the second hash: the first digest plus padding and length.
    function automatic logic [511:0] build_chunk3(input logic [255:0] h1);
        return {h1, PadWord, 160'b0, DigestLenBits};
    endfunction

endpackage

// File: rtl/sha256d_sequencer.sv
// sha256d_sequencer: sequences one external SHA-256 compression core through the
// three compressions of SHA-256(SHA-256(header)) for an 80-byte block header.
// Optional midstate cache (skips the first compression when the first 64 header
// bytes repeat) is enabled by defining SHA256D_MIDSTATE_CACHE_EN.
module sha256d_sequencer
    import sha256_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [639:0]      header,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [255:0]      digest,
    output logic [CNT_W-1:0]  hash_count,
    output logic              core_start,
    output logic [511:0]      core_chunk,
    output logic [255:0]      core_state_in,
    input  logic [255:0]      core_state_out,
    input  logic              core_finish
`ifdef SHA256D_MIDSTATE_CACHE_EN
    ,
    output logic              cache_hit
`endif
);

    seq_state_e       state_q, state_d;
    logic [127:0]     tail_q, tail_d;
    logic [511:0]     chunk_q, chunk_d;
    logic [255:0]     sin_q, sin_d;
    logic [255:0]     digest_q, digest_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q, out_valid_q, start_q;

    logic             accept;
    logic             cache_lookup;
    logic [255:0]     cached_mid;

    // in_ready_q is only ever set when the state register is StIdle.
    assign accept = in_valid && in_ready_q;

`ifdef SHA256D_MIDSTATE_CACHE_EN
    logic             cache_valid_q;
    logic [511:0]     cache_tag_q;
    logic [255:0]     cache_mid_q;

    // Capture the stage-1 midstate; during W1 the chunk register still holds header[639:128].
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_mid_q   <= '0;
        end else if (state_q == StW1 && core_finish) begin
            cache_valid_q <= 1'b1;
            cache_tag_q   <= chunk_q;
            cache_mid_q   <= core_state_out;
        end
    end

    assign cache_lookup = cache_valid_q && (cache_tag_q == header[639:128]);
    assign cached_mid   = cache_mid_q;
    assign cache_hit    = accept && cache_lookup;
`else
    assign cache_lookup = 1'b0;
    assign cached_mid   = '0;
`endif

    // Next-state logic; core inputs are loaded on entry to each C-state so they are
    // stable from the start pulse until the core reports completion.
    always_comb begin
        state_d  = state_q;
        tail_d   = tail_q;
        chunk_d  = chunk_q;
        sin_d    = sin_q;
        digest_d = digest_q;
        count_d  = count_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    tail_d = header[127:0];
                    if (cache_lookup) begin
                        state_d = StC2;
                        chunk_d = build_chunk2(header[127:0]);
                        sin_d   = cached_mid;
                    end else begin
                        state_d = StC1;
                        chunk_d = header[639:128];
                        sin_d   = Sha256Iv;
                    end
                end
            end
            StC1: state_d = StW1;
            StC2: state_d = StW2;
            StC3: state_d = StW3;
            StW1: begin
                if (core_finish) begin
                    state_d = StC2;
                    chunk_d = build_chunk2(tail_q);
                    sin_d   = core_state_out;
                end
            end
            StW2: begin
                if (core_finish) begin
                    state_d = StC3;
                    chunk_d = build_chunk3(core_state_out);
                    sin_d   = Sha256Iv;
                end
            end
            StW3: begin
                if (core_finish) begin
                    state_d  = StOut;
                    digest_d = core_state_out;
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; handshake/start outputs are registered from next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            tail_q      <= '0;
            chunk_q     <= '0;
            sin_q       <= '0;
            digest_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tail_q      <= tail_d;
            chunk_q     <= chunk_d;
            sin_q       <= sin_d;
            digest_q    <= digest_d;
            count_q     <= count_d;
            in_ready_q  <= (state_d == StIdle);
            out_valid_q <= (state_d == StOut);
            start_q     <= (state_d == StC1) || (state_d == StC2) || (state_d == StC3);
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign digest        = digest_q;
    assign hash_count    = count_q;
    assign core_start    = start_q;
    assign core_chunk    = chunk_q;
    assign core_state_in = sin_q;

endmodule
